// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing.
// Each frame is a start bit (0), eight data bits sent LSB first, and a stop bit (1).
// The line idles high.
// Bit timing comes from a free-running cycle counter that wraps every clk_cnt
// cycles while a frame is in flight, so every line bit lasts exactly clk_cnt clocks.
module uart_tx #(
    parameter int clk_freq  = 125000000,
    parameter int baud_rate = 62500,
    parameter int clk_cnt   = clk_freq / baud_rate
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    // Counter just wide enough to hold clk_cnt-1.
    localparam int CW = (clk_cnt > 2) ? $clog2(clk_cnt) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(clk_cnt - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_reg,  state_next;
    logic [CW-1:0] baud_reg,   baud_next;
    logic [2:0]    bit_reg,    bit_next;
    logic [7:0]    shift_reg,  shift_next;
    logic          tx_reg,     tx_next;
    logic          busy_reg,   busy_next;
    logic          done_reg,   done_next;
    logic          bit_end;

    // State and output registers; an active-low reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bit_end = (baud_reg == BAUD_LAST);

    // Next-state logic; every output is computed one cycle early so the pins come straight from flops.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        // The baud counter runs only while a frame is on the line.
        if (state_reg != IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + CW'(1);
        end

        case (state_reg)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                baud_next = '0;
                if (tx_start) begin
                    shift_next = tx_din;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next    = shift_reg[0];
                    bit_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        // After the shift, the new LSB is the old bit 1.
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                        bit_next   = bit_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx.
// The bench drives two instances: a fast one with 16 clocks per bit, and one with the default parameters.
// Stimulus pushes each byte it expects to see onto a queue.
// A monitor decodes every frame from the line, pops the matching byte and compares.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    uart_tx #(.clk_freq(16), .baud_rate(1)) dut0 (
        .clk(clk), .rst(rst), .tx_start(start0), .tx_din(din0),
        .tx(tx0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx dut1 (
        .clk(clk), .rst(rst), .tx_start(start1), .tx_din(din1),
        .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int gcyc  = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int         ndone[2]    = '{0, 0};
    logic       in_frame[2] = '{1'b0, 1'b0};
    int         fcyc[2]     = '{0, 0};
    logic [9:0] expf[2];
    int         bit_bad[2]  = '{0, 0};
    int         busy_bad[2] = '{0, 0};
    int         ldone[2]    = '{-1000, -1000};
    int         gap[2]      = '{0, 0};
    logic       last_tx[2];

    logic mt, mb, md;
    int   mcnt;

    task automatic chk(input bit ok, input string msg);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s", msg);
        end
    endtask

    // Monitor: decode frames at the falling edge and check them against the queued bytes.
    always @(negedge clk) begin
        gcyc++;
        for (int m = 0; m < 2; m++) begin
            mt   = (m == 0) ? tx0   : tx1;
            mb   = (m == 0) ? busy0 : busy1;
            md   = (m == 0) ? done0 : done1;
            mcnt = (m == 0) ? 16    : 2000;
            if (rst && md) ndone[m]++;
            if (!rst) begin
                in_frame[m] = 1'b0;
            end else begin
                if (!in_frame[m] && mb) begin
                    if (m == 0) begin
                        chk(q0.size() != 0, $sformatf("unexpected_frame m0 queued=%0d required>=1", q0.size()));
                        expf[m] = (q0.size() != 0) ? {1'b1, q0.pop_front(), 1'b0} : 10'h3FF;
                    end else begin
                        chk(q1.size() != 0, $sformatf("unexpected_frame m1 queued=%0d required>=1", q1.size()));
                        expf[m] = (q1.size() != 0) ? {1'b1, q1.pop_front(), 1'b0} : 10'h3FF;
                    end
                    in_frame[m] = 1'b1;
                    fcyc[m]     = 0;
                    bit_bad[m]  = 0;
                    busy_bad[m] = 0;
                    gap[m]      = gcyc - ldone[m];
                end
                if (in_frame[m]) begin
                    if (fcyc[m] < 10 * mcnt) begin
                        last_tx[m] = mt;
                        if (mt !== expf[m][fcyc[m] / mcnt]) bit_bad[m]++;
                        if (mb !== 1'b1 || md !== 1'b0) busy_bad[m]++;
                        if (fcyc[m] % mcnt == mcnt - 1) begin
                            chk(bit_bad[m] == 0,
                                $sformatf("line_bit m%0d idx%0d bad_samples=%0d required=0 last_tx=%b expected=%b",
                                          m, fcyc[m] / mcnt, bit_bad[m], last_tx[m], expf[m][fcyc[m] / mcnt]));
                            bit_bad[m] = 0;
                        end
                    end else begin
                        chk(busy_bad[m] == 0,
                            $sformatf("busy_len m%0d bad_cycles=%0d required=0", m, busy_bad[m]));
                        chk(md === 1'b1 && mb === 1'b0 && mt === 1'b1,
                            $sformatf("done_pulse m%0d done=%b busy=%b tx=%b required done=1 busy=0 tx=1", m, md, mb, mt));
                        ldone[m]    = gcyc;
                        in_frame[m] = 1'b0;
                    end
                    fcyc[m]++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy0(input logic want, input int limit);
        int k = 0;
        while (busy0 !== want && k < limit) begin
            step(1);
            k++;
        end
        chk(busy0 === want, $sformatf("wait_busy busy=%b required=%b within %0d cycles", busy0, want, limit));
    endtask

    int d0;

    // Stimulus: directed scenarios with expected bytes queued for the monitor.
    initial begin
        // 1: reset held with a start request pending
        start0 = 1'b1; din0 = 8'hFF; start1 = 1'b1; din1 = 8'hFF;
        repeat (5) begin
            step(1);
            chk(tx0 === 1'b1 && busy0 === 1'b0 && done0 === 1'b0,
                $sformatf("reset_hold tx=%b busy=%b done=%b required 1/0/0", tx0, busy0, done0));
        end
        start0 = 1'b0; start1 = 1'b0;
        rst = 1'b1;
        step(20);
        chk(tx0 === 1'b1 && busy0 === 1'b0, $sformatf("post_reset_idle tx=%b busy=%b required 1/0", tx0, busy0));
        chk(ndone[0] == 0, $sformatf("post_reset_done count=%0d required=0", ndone[0]));

        // 2: single byte A5
        d0 = ndone[0];
        q0.push_back(8'hA5);
        start0 = 1'b1; din0 = 8'hA5;
        step(1);
        start0 = 1'b0; din0 = 8'h00;
        step(200);
        chk(ndone[0] == d0 + 1, $sformatf("single_done count=%0d required=%0d", ndone[0] - d0, 1));

        // 3: back-to-back 00 then FF, tx_start held high
        d0 = ndone[0];
        q0.push_back(8'h00);
        q0.push_back(8'hFF);
        start0 = 1'b1; din0 = 8'h00;
        wait_busy0(1'b1, 5);
        din0 = 8'hFF;
        wait_busy0(1'b0, 200);
        wait_busy0(1'b1, 5);
        start0 = 1'b0;
        step(200);
        chk(gap[0] == 1, $sformatf("b2b_gap cycles=%0d required=1", gap[0]));
        chk(ndone[0] == d0 + 2, $sformatf("b2b_done count=%0d required=2", ndone[0] - d0));

        // 4: start request while busy is ignored
        d0 = ndone[0];
        q0.push_back(8'h3C);
        start0 = 1'b1; din0 = 8'h3C;
        step(1);
        start0 = 1'b0;
        step(80);
        start0 = 1'b1; din0 = 8'hC3;
        step(1);
        start0 = 1'b0; din0 = 8'h00;
        step(200);
        chk(ndone[0] == d0 + 1, $sformatf("ignore_busy_done count=%0d required=1", ndone[0] - d0));

        // 5: reset during data bit 3, then a clean frame
        d0 = ndone[0];
        q0.push_back(8'h55);
        start0 = 1'b1; din0 = 8'h55;
        step(1);
        start0 = 1'b0;
        step(70);
        rst = 1'b0;
        step(1);
        chk(tx0 === 1'b1 && busy0 === 1'b0 && done0 === 1'b0,
            $sformatf("mid_reset tx=%b busy=%b done=%b required 1/0/0", tx0, busy0, done0));
        rst = 1'b1;
        step(5);
        chk(ndone[0] == d0, $sformatf("mid_reset_done count=%0d required=0", ndone[0] - d0));
        q0.push_back(8'h81);
        start0 = 1'b1; din0 = 8'h81;
        step(1);
        start0 = 1'b0;
        step(200);
        chk(ndone[0] == d0 + 1, $sformatf("after_reset_done count=%0d required=1", ndone[0] - d0));

        // 6: default parameters, 2000 clocks per bit
        q1.push_back(8'h5A);
        start1 = 1'b1; din1 = 8'h5A;
        step(1);
        start1 = 1'b0;
        step(20100);
        chk(ndone[1] == 1, $sformatf("default_done count=%0d required=1", ndone[1]));

        chk(q0.size() == 0, $sformatf("q0_drained left=%0d required=0", q0.size()));
        chk(q1.size() == 0, $sformatf("q1_drained left=%0d required=0", q1.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1), idle line high. It accepts a byte through a single-cycle start handshake and serialises it at a baud rate derived from the system clock by an internal cycle counter. It is the transmit half of the UART path in the multi-protocol communication module.

Parameters:
clk_freq, 125000000, system clock frequency in Hz
baud_rate, 62500, line bit rate in bits/s
clk_cnt, clk_freq/baud_rate, system clock cycles per bit (default 2000); must be >= 2; the baud counter is sized to hold clk_cnt-1 (16 bits sufficient for defaults)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clk
tx_start  input  1  request to send tx_din; sampled only when tx_busy=0
tx_din  input  8  byte to send; captured in the cycle tx_start is accepted
tx  output  1  serial line, idle high
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Reset (rst=0 at an edge): tx=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit counter=0, shift register=0. This takes priority over everything, including mid-frame; the frame is abandoned and the line returns high on the next edge.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, tx_busy=0. If tx_start=1 in cycle T:
  - at edge T+1: latch tx_din into the shift register, tx=0, tx_busy=1, baud counter=0, state=START.
  - tx_start=0: remain in IDLE.
- Baud timing: the counter increments every clk cycle while not IDLE. When it reaches clk_cnt-1 it wraps to 0 and the bit ends. Each line bit is held exactly clk_cnt cycles. No separate enable strobe; the counter is free of drift, with no off-by-one across bits.
- START: after clk_cnt cycles, tx=shift[0], bit counter=0, state=DATA.
- DATA: at each bit end, shift right and drive the next LSB; the bit counter increments.
  - After the bit with index 7 ends: tx=1, state=STOP.
- STOP: after clk_cnt cycles, state=IDLE, tx_busy=0, tx_done=1 for exactly one cycle, tx stays 1.
- Frame length: tx_busy is high for exactly 10*clk_cnt cycles (T+1 .. T+10*clk_cnt). tx_done is high in cycle T+10*clk_cnt+1 only.
- Back-to-back: tx_start is accepted in the tx_done cycle (state is IDLE). The minimum inter-frame idle is 1 cycle beyond the stop bit. A held-high tx_start produces continuous frames with that 1-cycle gap.
- tx_start while tx_busy=1: ignored, with no queueing and no effect on the current frame. Changes on tx_din mid-frame have no effect.
- tx_done and tx_busy are never high together.
- Unreachable states recover to IDLE with tx=1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset: hold rst=0 for 5 cycles with tx_start=1 and tx_din=8'hFF -> tx=1, tx_busy=0, tx_done=0 throughout. On release with tx_start=0, the line stays idle.
2. Single byte (clk_freq=16, baud_rate=1 -> clk_cnt=16): pulse tx_start with tx_din=8'hA5 in cycle T -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles starting T+1; tx_busy high for 160 cycles; tx_done high only in cycle T+161.
3. Back-to-back with tx_start held high: send 8'h00 then 8'hFF -> second start bit begins exactly 1 cycle after the first frame's tx_done. Line pattern: 0 x9 then 1 (stop), gap high for 1 cycle, then 0, 1 x9. Two tx_done pulses in total.
4. Ignore while busy: start 8'h3C, then pulse tx_start with tx_din=8'hC3 at bit 4 -> transmitted bits still encode 8'h3C; exactly one tx_done; no second frame.
5. Reset mid-frame: assert rst=0 during DATA bit 3 of 8'h55 -> next edge tx=1, tx_busy=0, no tx_done. A new tx_start with 8'h81 after release -> a clean full frame.
6. Default parameters: send 8'h5A -> every bit period measured as exactly 2000 cycles; total frame 20000 cycles.
